// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Stall/flush control for the IF/ID and ID/EX pipeline registers
//            (load-use bubble, taken-branch squash, saturating event counters).
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_write_reg,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_STALL = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    localparam int                c_FL_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_FL_W-1:0] c_FL_INIT = c_FL_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]        r_state;
    logic [c_FL_W-1:0] r_flush_left;
    logic [CNT_W-1:0]  r_stall_count;
    logic [CNT_W-1:0]  r_flush_count;

    logic [1:0]        w_state_nxt;
    logic [c_FL_W-1:0] w_flush_left_nxt;
    logic              w_stall_inc;
    logic              w_flush_inc;
    logic              w_hz;

    // A load targeting x0 never produces a value, so it can never cause a stall.
    assign w_hz = ex_memRead && (ex_write_reg != 5'd0) &&
                  ((id_uses_rs1 && (id_rs1 == ex_write_reg)) ||
                   (id_uses_rs2 && (id_rs2 == ex_write_reg)));

    always_comb begin
        w_state_nxt      = c_ST_RUN;
        w_flush_left_nxt = r_flush_left;
        w_stall_inc      = 1'b0;
        w_flush_inc      = 1'b0;
        pc_write         = 1'b1;
        if_id_write      = 1'b1;
        if_id_flush      = 1'b0;
        id_ex_flush      = 1'b0;

        if (!rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_flush_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_state_nxt      = c_ST_FLUSH;
                w_flush_left_nxt = c_FL_INIT;
            end else begin
                w_flush_left_nxt = '0;
            end
        end else if (r_state == c_ST_FLUSH) begin
            // Squash window: load-use detection is meaningless on wrong-path instructions.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (r_flush_left > c_FL_W'(1)) begin
                w_state_nxt      = c_ST_FLUSH;
                w_flush_left_nxt = r_flush_left - c_FL_W'(1);
            end else begin
                w_flush_left_nxt = '0;
            end
        end else if (w_hz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            w_stall_inc = 1'b1;
            w_state_nxt = c_ST_STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_RUN;
            r_flush_left  <= '0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_left <= w_flush_left_nxt;
            if (w_stall_inc && (r_stall_count != c_CNT_MAX)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_count != c_CNT_MAX)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign ctrl_state  = r_state;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl (16-bit and 2-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_memRead;
    logic [4:0] ex_write_reg;
    logic       ex_branch_taken;

    logic        pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_count, flush_count;

    logic        d2_pc_write, d2_if_id_write, d2_if_id_flush, d2_id_ex_flush;
    logic [1:0]  d2_ctrl_state;
    logic [1:0]  d2_stall_count, d2_flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_memRead(ex_memRead), .ex_write_reg(ex_write_reg),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ctrl_state(ctrl_state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_memRead(ex_memRead), .ex_write_reg(ex_write_reg),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(d2_pc_write), .if_id_write(d2_if_id_write),
        .if_id_flush(d2_if_id_flush), .id_ex_flush(d2_id_ex_flush),
        .ctrl_state(d2_ctrl_state),
        .stall_count(d2_stall_count), .flush_count(d2_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs change at the falling edge; combinational outputs are sampled 2ns later,
    // registered values 1ns after the rising edge.
    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_memRead = 1'b0; ex_write_reg = 5'd0; ex_branch_taken = 1'b0;
    endtask

    task automatic drive_hz();
        ex_memRead = 1'b1; ex_write_reg = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    task automatic to_comb();
        @(negedge clk);
    endtask

    task automatic to_reg();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL rst_pc_write got=%0b exp=0", pc_write); end
        n_checks++; if (if_id_write !== 1'b0) begin n_fail++; $display("FAIL rst_if_id_write got=%0b exp=0", if_id_write); end
        n_checks++; if ({if_id_flush, id_ex_flush} !== 2'b11) begin n_fail++; $display("FAIL rst_flushes got=%b exp=11", {if_id_flush, id_ex_flush}); end
        n_checks++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin n_fail++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", stall_count, flush_count); end
        to_comb();
        rst_n = 1'b1;
        #2;
        n_checks++; if (ctrl_state !== 2'd0) begin n_fail++; $display("FAIL rel_state got=%0d exp=0", ctrl_state); end
        n_checks++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1100) begin n_fail++; $display("FAIL rel_outputs got=%b exp=1100", {pc_write, if_id_write, if_id_flush, id_ex_flush}); end
        to_reg();
        n_checks++; if (ctrl_state !== 2'd0) begin n_fail++; $display("FAIL idle_state got=%0d exp=0", ctrl_state); end
    endtask

    task automatic test_load_use();
        to_comb();
        drive_hz();
        #2;
        n_checks++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b0001) begin n_fail++; $display("FAIL lu_outputs got=%b exp=0001", {pc_write, if_id_write, if_id_flush, id_ex_flush}); end
        to_reg();
        n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_stall_count got=%0d exp=1", stall_count); end
        n_checks++; if (ctrl_state !== 2'd1) begin n_fail++; $display("FAIL lu_state_stall got=%0d exp=1", ctrl_state); end
        to_comb();
        idle_inputs();
        #2;
        n_checks++; if ({pc_write, if_id_write, id_ex_flush} !== 3'b110) begin n_fail++; $display("FAIL lu_release got=%b exp=110", {pc_write, if_id_write, id_ex_flush}); end
        to_reg();
        n_checks++; if (ctrl_state !== 2'd0) begin n_fail++; $display("FAIL lu_state_run got=%0d exp=0", ctrl_state); end
    endtask

    task automatic test_no_hazard();
        to_comb();
        ex_memRead = 1'b1; ex_write_reg = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
        #2;
        n_checks++; if ({pc_write, id_ex_flush} !== 2'b10) begin n_fail++; $display("FAIL x0_outputs got=%b exp=10", {pc_write, id_ex_flush}); end
        to_reg();
        n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL x0_stall_count got=%0d exp=1", stall_count); end
        to_comb();
        ex_write_reg = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
        #2;
        n_checks++; if ({pc_write, id_ex_flush} !== 2'b10) begin n_fail++; $display("FAIL unused_rs2_outputs got=%b exp=10", {pc_write, id_ex_flush}); end
        to_reg();
        n_checks++; if (stall_count !== 16'd1 || ctrl_state !== 2'd0) begin n_fail++; $display("FAIL unused_rs2_regs got=%0d/%0d exp=1/0", stall_count, ctrl_state); end
        to_comb();
        idle_inputs();
    endtask

    task automatic test_branch();
        to_comb();
        ex_branch_taken = 1'b1;
        #2;
        n_checks++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1111) begin n_fail++; $display("FAIL br_cycle1 got=%b exp=1111", {pc_write, if_id_write, if_id_flush, id_ex_flush}); end
        to_reg();
        n_checks++; if (flush_count !== 16'd1 || ctrl_state !== 2'd2) begin n_fail++; $display("FAIL br_regs got=%0d/%0d exp=1/2", flush_count, ctrl_state); end
        // A load-use pattern during the squash window must be ignored.
        to_comb();
        ex_branch_taken = 1'b0;
        drive_hz();
        #2;
        n_checks++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1111) begin n_fail++; $display("FAIL br_cycle2 got=%b exp=1111", {pc_write, if_id_write, if_id_flush, id_ex_flush}); end
        to_reg();
        n_checks++; if (ctrl_state !== 2'd0 || stall_count !== 16'd1) begin n_fail++; $display("FAIL br_end got=%0d/%0d exp=0/1", ctrl_state, stall_count); end
        to_comb();
        idle_inputs();
        #2;
        n_checks++; if ({if_id_flush, id_ex_flush} !== 2'b00) begin n_fail++; $display("FAIL br_cycle3 got=%b exp=00", {if_id_flush, id_ex_flush}); end
        to_reg();
    endtask

    task automatic test_branch_and_hz();
        to_comb();
        drive_hz();
        ex_branch_taken = 1'b1;
        #2;
        n_checks++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1111) begin n_fail++; $display("FAIL brhz_outputs got=%b exp=1111", {pc_write, if_id_write, if_id_flush, id_ex_flush}); end
        to_reg();
        n_checks++; if (stall_count !== 16'd1 || flush_count !== 16'd2) begin n_fail++; $display("FAIL brhz_counts got=%0d/%0d exp=1/2", stall_count, flush_count); end
        to_comb();
        idle_inputs();
        to_reg();
        n_checks++; if (ctrl_state !== 2'd0) begin n_fail++; $display("FAIL brhz_state got=%0d exp=0", ctrl_state); end
    endtask

    task automatic test_back_to_back();
        to_comb();
        ex_branch_taken = 1'b1;
        to_reg();
        to_comb();
        to_reg();
        // Second branch in FLUSH restarts the window: still FLUSH after it.
        n_checks++; if (ctrl_state !== 2'd2 || flush_count !== 16'd4) begin n_fail++; $display("FAIL b2b_restart got=%0d/%0d exp=2/4", ctrl_state, flush_count); end
        to_comb();
        ex_branch_taken = 1'b0;
        #2;
        n_checks++; if ({if_id_flush, id_ex_flush} !== 2'b11) begin n_fail++; $display("FAIL b2b_tail got=%b exp=11", {if_id_flush, id_ex_flush}); end
        to_reg();
        n_checks++; if (ctrl_state !== 2'd0) begin n_fail++; $display("FAIL b2b_state got=%0d exp=0", ctrl_state); end
    endtask

    task automatic test_saturate_and_abort();
        to_comb();
        rst_n = 1'b0;
        to_comb();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            to_comb();
            drive_hz();
            to_reg();
            to_comb();
            idle_inputs();
            to_reg();
        end
        n_checks++; if (d2_stall_count !== 2'd3) begin n_fail++; $display("FAIL sat_stall_count2 got=%0d exp=3", d2_stall_count); end
        n_checks++; if (stall_count !== 16'd5) begin n_fail++; $display("FAIL sat_stall_count16 got=%0d exp=5", stall_count); end
        to_comb();
        ex_branch_taken = 1'b1;
        to_reg();
        ex_branch_taken = 1'b0;
        n_checks++; if (d2_ctrl_state !== 2'd2 || d2_flush_count !== 2'd1) begin n_fail++; $display("FAIL abort_pre got=%0d/%0d exp=2/1", d2_ctrl_state, d2_flush_count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (d2_ctrl_state !== 2'd0 || d2_stall_count !== 2'd0 || d2_flush_count !== 2'd0) begin n_fail++; $display("FAIL abort_regs2 got=%0d/%0d/%0d exp=0/0/0", d2_ctrl_state, d2_stall_count, d2_flush_count); end
        n_checks++; if (ctrl_state !== 2'd0 || stall_count !== 16'd0 || flush_count !== 16'd0) begin n_fail++; $display("FAIL abort_regs16 got=%0d/%0d/%0d exp=0/0/0", ctrl_state, stall_count, flush_count); end
        n_checks++; if ({d2_pc_write, d2_if_id_write, d2_if_id_flush, d2_id_ex_flush} !== 4'b0011) begin n_fail++; $display("FAIL abort_outputs got=%b exp=0011", {d2_pc_write, d2_if_id_write, d2_if_id_flush, d2_id_ex_flush}); end
        to_comb();
        rst_n = 1'b1;
        to_reg();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_branch_and_hz();
        test_back_to_back();
        test_saturate_and_abort();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
